// File: rtl/reg_file_sb.sv
// reg_file_sb -- general-purpose register file with a pending-write scoreboard
// and a sequential clear engine.
//
// Two combinational read ports and one synchronous write port. A busy bit per
// register records an issued instruction whose result has not yet been written
// back, so the control FSM can stall on RAW hazards. A clear request walks the
// file one register per cycle, zeroing data and busy bits, without needing a
// global reset.
//
// Optional build macro: REG_FILE_BYPASS_EN
//   defined   -> same-cycle write-to-read forwarding on both read ports
//   undefined -> reads return the stored value only
//
// Ports:
//   Clk          in   rising-edge clock
//   Reset        in   asynchronous active-low reset
//   wr_en        in   write strobe (honoured in IDLE only)
//   wr_addr      in   destination register
//   wr_data      in   write data
//   rd_addr_a/b  in   read selects
//   rd_data_a/b  out  read data
//   sb_set_en    in   mark sb_set_addr as pending-write (IDLE only)
//   sb_set_addr  in   register to mark
//   busy_a/b     out  scoreboard bit of rd_addr_a/b
//   clr_req      in   start a full clear (sampled in IDLE only)
//   clr_busy     out  high while the clear engine owns the write port
//   clr_done     out  one-cycle pulse when the clear finishes
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ZERO_R0  = 0,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              sb_set_en,
    input  logic [ADDR_W-1:0] sb_set_addr,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] sb_q, sb_d;
    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic idle;
    logic wr_ok;
    logic set_ok;

    assign idle = (state_q == ST_IDLE);

    // Writes and busy-sets to R0 are dropped when R0 is hardwired to zero.
    assign wr_ok  = wr_en && idle && !((ZERO_R0 != 0) && (wr_addr == '0));
    assign set_ok = sb_set_en && idle && !((ZERO_R0 != 0) && (sb_set_addr == '0));

    always_comb begin
        regs_d  = regs_q;
        sb_d    = sb_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_ok) begin
                    regs_d[wr_addr] = wr_data;
                    sb_d[wr_addr]   = 1'b0;
                end
                // Applied after the writeback so a same-edge set on the
                // same register leaves the bit set.
                if (set_ok) begin
                    sb_d[sb_set_addr] = 1'b1;
                end
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                regs_d[cnt_q] = '0;
                sb_d[cnt_q]   = 1'b0;
                // Terminal compare stops the walk before the counter wraps.
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            sb_q    <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            sb_q    <= sb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clr_busy = (state_q == ST_CLEAR);
    assign clr_done = (state_q == ST_DONE);

    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        rd_data_b = regs_q[rd_addr_b];
        busy_a    = sb_q[rd_addr_a];
        busy_b    = sb_q[rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
        // Forward the in-flight write; busy reflects the writeback unless a
        // new issue targets the same register on this edge.
        if (wr_ok && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
            busy_a    = set_ok && (sb_set_addr == wr_addr);
        end
        if (wr_ok && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
            busy_b    = set_ok && (sb_set_addr == wr_addr);
        end
`endif
        if ((ZERO_R0 != 0) && (rd_addr_a == '0)) begin
            rd_data_a = '0;
        end
        if ((ZERO_R0 != 0) && (rd_addr_b == '0)) begin
            rd_data_b = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        wr_en, sb_set_en, clr_req;
    logic [2:0]  wr_addr, rd_addr_a, rd_addr_b, sb_set_addr;
    logic [15:0] wr_data;

    // dut: ZERO_R0=0, dut_z: ZERO_R0=1; both see the same stimulus.
    logic [15:0] rda0, rdb0, rdaz, rdbz;
    logic        ba0, bb0, cb0, cd0, baz, bbz, cbz, cdz;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural register contents and busy flags.
    logic [15:0] mem [2][8];
    logic [7:0]  sbm [2];

    always #5 Clk = ~Clk;

    reg_file_sb #(.DATA_W(16), .NUM_REGS(8), .ZERO_R0(0)) dut (
        .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda0), .rd_addr_b(rd_addr_b), .rd_data_b(rdb0),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_a(ba0), .busy_b(bb0),
        .clr_req(clr_req), .clr_busy(cb0), .clr_done(cd0)
    );

    reg_file_sb #(.DATA_W(16), .NUM_REGS(8), .ZERO_R0(1)) dut_z (
        .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rdaz), .rd_addr_b(rd_addr_b), .rd_data_b(rdbz),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_a(baz), .busy_b(bbz),
        .clr_req(clr_req), .clr_busy(cbz), .clr_done(cdz)
    );

    task automatic drive_idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0; clr_req = 1'b0;
    endtask

    task automatic model_clear();
        for (int z = 0; z < 2; z++) begin
            sbm[z] = '0;
            for (int i = 0; i < 8; i++) mem[z][i] = '0;
        end
    endtask

    // Advance one clock edge, applying the architectural effect of the inputs
    // held across it (model assumes the file is idle; clear tests re-zero it).
    task automatic tick();
        @(posedge Clk);
        for (int z = 0; z < 2; z++) begin
            if (wr_en && !(z == 1 && wr_addr == 3'd0)) begin
                mem[z][wr_addr] = wr_data;
                sbm[z][wr_addr] = 1'b0;
            end
            if (sb_set_en && !(z == 1 && sb_set_addr == 3'd0)) sbm[z][sb_set_addr] = 1'b1;
        end
        #1;
    endtask

    function automatic logic [15:0] exp_rd(int z, logic [2:0] a);
        if (z == 1 && a == 3'd0) return 16'h0000;
        if (BYP && wr_en && a == wr_addr) return wr_data;
        return mem[z][a];
    endfunction

    function automatic logic exp_busy(int z, logic [2:0] a);
        if (BYP && wr_en && a == wr_addr && !(z == 1 && a == 3'd0))
            return sb_set_en && (sb_set_addr == a);
        return sbm[z][a];
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'($urandom);
            sb_set_en = 1'b1; sb_set_addr = 3'(7 - i);
            tick();
        end
        drive_idle();
        rd_addr_a = 3'd1;
        #2 Reset = 1'b0;
        #1;
        total++; if (rda0 !== 16'h0000) begin bad++; $display("FAIL reset_async_rd got=%h exp=0000", rda0); end
        total++; if (cb0 !== 1'b0 || cd0 !== 1'b0) begin bad++; $display("FAIL reset_clr_flags got=%b%b exp=00", cb0, cd0); end
        model_clear();
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
            #1;
            total++; if (rda0 !== 16'h0000 || rdb0 !== 16'h0000) begin bad++; $display("FAIL reset_rd[%0d] got=%h/%h exp=0000", i, rda0, rdb0); end
            total++; if (ba0 !== 1'b0 || bb0 !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b/%b exp=0", i, ba0, bb0); end
            total++; if (cb0 !== 1'b0) begin bad++; $display("FAIL reset_clr_busy got=%b exp=0", cb0); end
        end
    endtask

    task automatic test_write_latency();
        drive_idle();
        rd_addr_a = 3'd3; rd_addr_b = 3'd3;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
        #1;
        total++; if (rda0 !== (BYP ? 16'h1234 : 16'h0000)) begin bad++; $display("FAIL wr_lat_t got=%h exp=%h", rda0, BYP ? 16'h1234 : 16'h0000); end
        tick();
        drive_idle();
        #1;
        total++; if (rda0 !== 16'h1234 || rdb0 !== 16'h1234) begin bad++; $display("FAIL wr_lat_t1 got=%h/%h exp=1234", rda0, rdb0); end
        total++; if (rdaz !== 16'h1234) begin bad++; $display("FAIL wr_lat_t1_z got=%h exp=1234", rdaz); end
    endtask

    task automatic test_scoreboard();
        drive_idle();
        rd_addr_a = 3'd5;
        sb_set_en = 1'b1; sb_set_addr = 3'd5;
        tick();
        drive_idle();
        #1;
        total++; if (ba0 !== 1'b1) begin bad++; $display("FAIL sb_pend_c1 got=%b exp=1", ba0); end
        tick();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
        #1;
        total++; if (ba0 !== (BYP ? 1'b0 : 1'b1)) begin bad++; $display("FAIL sb_pend_c2 got=%b exp=%b", ba0, !BYP); end
        tick();
        drive_idle();
        #1;
        total++; if (ba0 !== 1'b0 || rda0 !== 16'hBEEF) begin bad++; $display("FAIL sb_retire got=%b/%h exp=0/beef", ba0, rda0); end
        // Same-edge set and writeback on one register: set wins.
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
        sb_set_en = 1'b1; sb_set_addr = 3'd5;
        #1;
        total++; if (ba0 !== (BYP ? 1'b1 : 1'b0)) begin bad++; $display("FAIL sb_same_edge_now got=%b exp=%b", ba0, BYP); end
        tick();
        drive_idle();
        #1;
        total++; if (ba0 !== 1'b1 || rda0 !== 16'hBEEF) begin bad++; $display("FAIL sb_same_edge got=%b/%h exp=1/beef", ba0, rda0); end
        // Set and writeback to different registers both apply.
        rd_addr_a = 3'd1; rd_addr_b = 3'd6;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1111;
        sb_set_en = 1'b1; sb_set_addr = 3'd6;
        tick();
        drive_idle();
        #1;
        total++; if (ba0 !== 1'b0 || rda0 !== 16'h1111 || bb0 !== 1'b1) begin bad++; $display("FAIL sb_diff got=%b/%h/%b exp=0/1111/1", ba0, rda0, bb0); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'hFFFF;
            sb_set_en = (i == 2); sb_set_addr = 3'd6;
            tick();
        end
        drive_idle();
        rd_addr_a = 3'd0; rd_addr_b = 3'd7;
        clr_req = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            drive_idle();
            total++; if (cb0 !== 1'b1 || cd0 !== 1'b0) begin bad++; $display("FAIL clr_cycle%0d got busy=%b done=%b exp=1/0", k, cb0, cd0); end
            total++; if (rda0 !== (k >= 2 ? 16'h0000 : 16'hFFFF) || rdb0 !== 16'hFFFF) begin bad++; $display("FAIL clr_partial%0d got=%h/%h", k, rda0, rdb0); end
            if (k == 4) clr_req = 1'b1;
            if (k == 6) begin
                wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h5555;
                sb_set_en = 1'b1; sb_set_addr = 3'd1;
            end
            tick();
        end
        drive_idle();
        total++; if (cb0 !== 1'b0 || cd0 !== 1'b1) begin bad++; $display("FAIL clr_done_pulse got busy=%b done=%b exp=0/1", cb0, cd0); end
        tick();
        total++; if (cb0 !== 1'b0 || cd0 !== 1'b0) begin bad++; $display("FAIL clr_after_done got busy=%b done=%b exp=0/0", cb0, cd0); end
        model_clear();
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            #1;
            total++; if (rda0 !== 16'h0000 || ba0 !== 1'b0) begin bad++; $display("FAIL clr_final[%0d] got=%h/%b exp=0000/0", i, rda0, ba0); end
        end
    endtask

    task automatic test_clear_held();
        int n;
        drive_idle();
        clr_req = 1'b1;
        tick();
        n = 0;
        while (cd0 !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (cd0 !== 1'b1) begin bad++; $display("FAIL held_first_done timeout got=%b exp=1", cd0); end
        tick();
        total++; if (cb0 !== 1'b0 || cd0 !== 1'b0) begin bad++; $display("FAIL held_idle got=%b%b exp=00", cb0, cd0); end
        tick();
        total++; if (cb0 !== 1'b1) begin bad++; $display("FAIL held_restart got=%b exp=1", cb0); end
        clr_req = 1'b0;
        n = 0;
        while (cd0 !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (cd0 !== 1'b1) begin bad++; $display("FAIL held_second_done timeout got=%b exp=1", cd0); end
        tick();
        model_clear();
    endtask

    task automatic test_reset_mid_clear();
        drive_idle();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h3333; tick();
        wr_addr = 3'd6; wr_data = 16'h6666; tick();
        drive_idle();
        rd_addr_a = 3'd3; rd_addr_b = 3'd6;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick();
        total++; if (cb0 !== 1'b1 || rda0 !== 16'h3333) begin bad++; $display("FAIL rmc_before got=%b/%h exp=1/3333", cb0, rda0); end
        #2 Reset = 1'b0;
        #1;
        total++; if (cb0 !== 1'b0 || cd0 !== 1'b0) begin bad++; $display("FAIL rmc_abort got=%b%b exp=00", cb0, cd0); end
        total++; if (rda0 !== 16'h0000 || rdb0 !== 16'h0000) begin bad++; $display("FAIL rmc_regs got=%h/%h exp=0000", rda0, rdb0); end
        @(negedge Clk);
        Reset = 1'b1;
        model_clear();
        for (int i = 0; i < 12; i++) begin
            tick();
            total++; if (cd0 !== 1'b0 || cb0 !== 1'b0) begin bad++; $display("FAIL rmc_no_done[%0d] got=%b%b exp=00", i, cb0, cd0); end
        end
    endtask

    task automatic test_zero_r0();
        drive_idle();
        rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hAAAA;
        sb_set_en = 1'b1; sb_set_addr = 3'd0;
        #1;
        total++; if (rdaz !== 16'h0000 || baz !== 1'b0) begin bad++; $display("FAIL z0_now got=%h/%b exp=0000/0", rdaz, baz); end
        total++; if (rda0 !== (BYP ? 16'hAAAA : 16'h0000)) begin bad++; $display("FAIL z0_plain_now got=%h", rda0); end
        tick();
        drive_idle();
        #1;
        total++; if (rdaz !== 16'h0000 || baz !== 1'b0 || bbz !== 1'b0) begin bad++; $display("FAIL z0_next got=%h/%b exp=0000/0", rdaz, baz); end
        total++; if (rda0 !== 16'hAAAA || ba0 !== 1'b1) begin bad++; $display("FAIL z0_plain_next got=%h/%b exp=aaaa/1", rda0, ba0); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = 3'($urandom); wr_data = 16'($urandom);
            sb_set_en = ($urandom_range(0, 2) == 0);
            sb_set_addr = 3'($urandom);
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
            rd_addr_b = 3'($urandom);
            clr_req = 1'b0;
            #3;
            total++; if (rda0 !== exp_rd(0, rd_addr_a)) begin bad++; $display("FAIL rnd%0d rd_a got=%h exp=%h", c, rda0, exp_rd(0, rd_addr_a)); end
            total++; if (rdb0 !== exp_rd(0, rd_addr_b)) begin bad++; $display("FAIL rnd%0d rd_b got=%h exp=%h", c, rdb0, exp_rd(0, rd_addr_b)); end
            total++; if (ba0 !== exp_busy(0, rd_addr_a) || bb0 !== exp_busy(0, rd_addr_b)) begin bad++; $display("FAIL rnd%0d busy got=%b%b exp=%b%b", c, ba0, bb0, exp_busy(0, rd_addr_a), exp_busy(0, rd_addr_b)); end
            total++; if (rdaz !== exp_rd(1, rd_addr_a) || rdbz !== exp_rd(1, rd_addr_b)) begin bad++; $display("FAIL rnd%0d z_rd got=%h/%h exp=%h/%h", c, rdaz, rdbz, exp_rd(1, rd_addr_a), exp_rd(1, rd_addr_b)); end
            total++; if (baz !== exp_busy(1, rd_addr_a) || bbz !== exp_busy(1, rd_addr_b)) begin bad++; $display("FAIL rnd%0d z_busy got=%b%b exp=%b%b", c, baz, bbz, exp_busy(1, rd_addr_a), exp_busy(1, rd_addr_b)); end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        Reset = 1'b0;
        drive_idle();
        rd_addr_a = '0; rd_addr_b = '0;
        model_clear();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        test_reset();
        test_write_latency();
        test_scoreboard();
        test_clear();
        test_clear_held();
        test_reset_mid_clear();
        test_zero_r0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised general-purpose register file for the LC-3-style datapath.
- Provides two asynchronous read ports and one synchronous write port.
- Adds a per-register scoreboard (pending-write busy bits) so the control FSM can detect RAW hazards.
- A sequential clear engine zeroes the whole file on request, one register per cycle, without a global reset.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of registers; must be a power of two, at least 2.
- ZERO_R0, 0, if 1, register 0 always reads 0 and writes to it are dropped; its busy bit never sets.
- ADDR_W, $clog2(NUM_REGS), derived address width; not overridden.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  destination register.
- wr_data  in  DATA_W  write data (bus value).
- rd_addr_a  in  ADDR_W  read port A select (SR1).
- rd_data_a  out  DATA_W  read port A data.
- rd_addr_b  in  ADDR_W  read port B select (SR2).
- rd_data_b  out  DATA_W  read port B data.
- sb_set_en  in  1  mark a register as pending-write (instruction issued).
- sb_set_addr  in  ADDR_W  register to mark.
- busy_a  out  1  scoreboard bit of rd_addr_a.
- busy_b  out  1  scoreboard bit of rd_addr_b.
- clr_req  in  1  request a full clear, sampled in IDLE only.
- clr_busy  out  1  high while the clear engine owns the write port.
- clr_done  out  1  one-cycle pulse when the clear finishes.

Behaviour:
- Reset (Reset low, asynchronous):
  - all registers = 0; scoreboard = 0; FSM = IDLE; clear counter = 0.
  - clr_busy = 0, clr_done = 0.
  - A reset mid-clear aborts immediately; no clr_done is issued.
- Reads:
  - combinational from the stored array.
  - busy_a/busy_b are combinational from the registered scoreboard only.
- Writes:
  - on a rising Clk edge with wr_en=1 and FSM=IDLE, reg[wr_addr] <= wr_data and sb[wr_addr] <= 0 (writeback retires the pending write).
  - Write latency 1 cycle: the value is visible on the read ports the cycle after the edge.
- Scoreboard set:
  - sb_set_en=1 in IDLE sets sb[sb_set_addr].
  - Same-edge set and writeback to the same address: set wins (bit = 1), data is still written.
  - Set and writeback to different addresses both take effect.
- ZERO_R0=1:
  - rd_data_x = 0 whenever rd_addr_x = 0.
  - writes and sb sets to address 0 are ignored.
- Clear FSM:
  - IDLE: clr_req=1 -> CLEAR, counter = 0. Otherwise stay.
  - CLEAR: clr_busy=1. Each cycle reg[counter] <= 0, sb[counter] <= 0, counter++. When counter = NUM_REGS-1 -> DONE.
  - CLEAR total duration is NUM_REGS cycles.
  - DONE: clr_done=1 for exactly one cycle, clr_busy=0 -> IDLE.
- During CLEAR and DONE:
  - wr_en and sb_set_en are ignored; the caller must hold off.
  - clr_req is ignored; it is not queued.
  - Reads remain live and show partially cleared contents.
- clr_req held high continuously: a new clear starts on the cycle after DONE, in IDLE.
- Counter is ADDR_W wide; the terminal compare prevents wrap-around.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - write-to-read forwarding. If wr_en=1, FSM=IDLE and rd_addr_x = wr_addr (and not blocked by ZERO_R0), rd_data_x = wr_data in the same cycle and busy_x = 0.
  - Exception: if sb_set_en targets the same address that cycle, busy_x = 1.
- Undefined:
  - reads return the stored value only; a same-cycle write is visible next cycle.
  - busy_x reflects the registered scoreboard.

Test Plan:
- Reset low mid-run, then release; read all 8 addresses -> every rd_data = 0x0000, busy = 0, clr_busy = 0.
- Write 0x1234 to R3 at cycle t; rd_addr_a=3 at t -> 0x0000 without the macro, 0x1234 with it. At t+1 -> 0x1234 in both builds.
- sb_set R5, then wr_en R5 = 0xBEEF two cycles later -> busy_a(5) is 1 for 2 cycles, then 0; read = 0xBEEF. Same-edge set+write on R5 -> busy stays 1, data = 0xBEEF.
- Load R0..R7 = 0xFFFF, pulse clr_req -> clr_busy high exactly 8 cycles, clr_done single pulse on the 9th, all regs 0. wr_en R2=0x5555 during CLEAR is dropped (R2 = 0).
- Assert Reset low on the 4th CLEAR cycle -> clr_busy drops immediately, no clr_done, all regs 0.
- ZERO_R0=1: write 0xAAAA to R0 with sb_set R0 -> rd_data_a(0) = 0, busy_a = 0.
